// File: rtl/arb_merge_pkg.sv
// -----------------------------------------------------------------------------
// arb_merge_pkg
// Shared definitions for the arb_merge round-robin merge and its arbiter.
//   - arb_state_e      : merge FSM state encoding (ARB_IDLE / ARB_BUSY)
//   - RESP_READY       : bit position of ready inside a response word
//   - req_width()      : request word width  = valid + addr + data + strobes
//   - resp_width()     : response word width = {rdata, ready}
//   - idx_width()      : width of a master index, never less than 1 bit
// Request word layout (MSB..LSB) : {valid, addr, wdata, wstrb}
// Response word layout (MSB..LSB): {rdata, ready}
// -----------------------------------------------------------------------------
package arb_merge_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int RESP_READY = 0;

  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_width(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_merge_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts just after the
// previously served master and wraps, so the first requester at or after
// last+1 (mod N) wins.
// Ports:
//   req_i     [N-1:0]  request (valid) bit per master
//   last_i    [IW-1:0] index of the master served last
//   winner_o  [IW-1:0] index of the winning master (0 when none)
//   any_req_o          at least one master is requesting
// -----------------------------------------------------------------------------
module rr_arbiter
  import arb_merge_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] winner_o,
  output logic          any_req_o
);

  // Two passes realise the wrap: first masters above last, then the rest.
  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!any_req_o && req_i[j] && (j > int'(last_i))) begin
        any_req_o = 1'b1;
        winner_o  = IW'(j);
      end else begin
        any_req_o = any_req_o;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!any_req_o && req_i[j] && (j <= int'(last_i))) begin
        any_req_o = 1'b1;
        winner_o  = IW'(j);
      end else begin
        any_req_o = any_req_o;
      end
    end
  end

endmodule

// File: rtl/arb_merge.sv
// -----------------------------------------------------------------------------
// arb_merge
// Registered round-robin merge of N_MASTERS native-bus masters onto a single
// request/response pair. One master is granted at a time; the grant is held
// until the downstream ready pulse (or a valid drop) closes the transaction,
// followed by one IDLE bubble cycle before the next grant.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   m_req        concatenated master requests, master i at [i*REQ_W +: REQ_W]
//   m_resp       concatenated master responses, master i at [i*RESP_W +: RESP_W]
//   s_req        merged request towards the downstream split
//   s_resp       response from the downstream split
//   busy         a transaction is in flight
//   grant        index of the current / last granted master
//   timeout_err  sticky watchdog flag (only with ARB_MERGE_TIMEOUT_EN)
//
// Optional feature macro: ARB_MERGE_TIMEOUT_EN
//   When defined, a watchdog aborts a transaction on its TIMEOUT-th BUSY
//   cycle without ready, answering the granted master with all-ones rdata
//   and ready, and sets timeout_err until reset.
// -----------------------------------------------------------------------------
module arb_merge
  import arb_merge_pkg::*;
#(
  parameter  int N_MASTERS = 2,
  parameter  int DATA_W    = 32,
  parameter  int ADDR_W    = 32,
  parameter  int TIMEOUT   = 1024,
  localparam int REQ_W     = req_width(ADDR_W, DATA_W),
  localparam int RESP_W    = resp_width(DATA_W),
  localparam int GW        = idx_width(N_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [REQ_W-1:0]              s_req,
  input  logic [RESP_W-1:0]             s_resp,
  output logic                          busy,
  output logic [GW-1:0]                 grant
`ifdef ARB_MERGE_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam int REQ_VALID = REQ_W - 1;

  arb_state_e      state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q,  last_d;

  logic [REQ_W-1:0]     req_arr_s [N_MASTERS];
  logic [N_MASTERS-1:0] valid_vec_s;
  logic [REQ_W-1:0]     gnt_req_s;
  logic                 gnt_valid_s;
  logic                 s_ready_s;
  logic [GW-1:0]        winner_s;
  logic                 any_req_s;
  logic                 timeout_hit_s;

  // Split the concatenated request bus into per-master words and valid bits.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      req_arr_s[i]   = m_req[i*REQ_W +: REQ_W];
      valid_vec_s[i] = m_req[i*REQ_W + REQ_VALID];
    end
  end

  assign gnt_req_s   = req_arr_s[grant_q];
  assign gnt_valid_s = gnt_req_s[REQ_VALID];
  assign s_ready_s   = s_resp[RESP_READY];

  rr_arbiter #(
    .N (N_MASTERS)
  ) u_rr_arbiter (
    .req_i     (valid_vec_s),
    .last_i    (last_q),
    .winner_o  (winner_s),
    .any_req_o (any_req_s)
  );

`ifdef ARB_MERGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Ready wins over the watchdog when both land on the same cycle.
  assign timeout_hit_s = (state_q == ARB_BUSY) && !s_ready_s &&
                         (cnt_q == CNT_W'(TIMEOUT - 1));

  // Watchdog next-state: clear on grant, count stalled BUSY cycles, sticky flag.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | timeout_hit_s;
    if (state_q == ARB_IDLE) begin
      cnt_d = '0;
    end else if (!s_ready_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_hit_s = 1'b0;
`endif

  // FSM next-state: grant in IDLE, close on ready, timeout or valid drop.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req_s) begin
          state_d = ARB_BUSY;
          grant_d = winner_s;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        // Ready with a simultaneous valid drop still counts as completion.
        if (s_ready_s || timeout_hit_s || !gnt_valid_s) begin
          state_d = ARB_IDLE;
          last_d  = grant_q;
        end else begin
          state_d = ARB_BUSY;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // FSM and pointer registers; last resets to N-1 so master 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Routing is combinational from the state/grant registers so a reset or a
  // valid drop by the granted master reaches the slave in the same cycle.
  always_comb begin
    s_req  = '0;
    m_resp = '0;
    if ((state_q == ARB_BUSY) && !timeout_hit_s) begin
      s_req = gnt_req_s;
    end else begin
      s_req = '0;
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      if ((state_q == ARB_BUSY) && (grant_q == GW'(i))) begin
        m_resp[i*RESP_W +: RESP_W] = timeout_hit_s ? {RESP_W{1'b1}} : s_resp;
      end else begin
        m_resp[i*RESP_W +: RESP_W] = '0;
      end
    end
  end

  assign busy  = (state_q == ARB_BUSY);
  assign grant = grant_q;

endmodule

// File: tb/tb_arb_merge.sv
// Directed, table-driven bench for arb_merge with three masters.
module tb_arb_merge;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 1 + AW + DW + DW / 8;
  localparam int SW = DW + 1;

  logic            clk;
  logic            rst_n;
  logic [N*RW-1:0] m_req;
  logic [N*SW-1:0] m_resp;
  logic [RW-1:0]   s_req;
  logic [SW-1:0]   s_resp;
  logic            busy;
  logic [1:0]      grant;
`ifdef ARB_MERGE_TIMEOUT_EN
  logic            timeout_err;
`endif

  int checks   = 0;
  int failures = 0;

  arb_merge #(
    .N_MASTERS (N),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .TIMEOUT   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_req       (m_req),
    .m_resp      (m_resp),
    .s_req       (s_req),
    .s_resp      (s_resp),
    .busy        (busy),
    .grant       (grant)
`ifdef ARB_MERGE_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  v;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_busy;
    logic [1:0]  e_grant;
    int          e_route;   // 3 = nothing routed
  } vec_t;

  vec_t tbl[$];

  // Master i payload: addr 0x10*(i+1), distinct wdata and strobes.
  function automatic logic [RW-1:0] req_of(input int i, input logic v);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    s;
    a = AW'(32'h10 * (i + 1));
    d = 32'hD000_0000 + DW'(i);
    s = 4'hF - 4'(i);
    return {v, a, d, s};
  endfunction

  task automatic add(input logic [2:0] v, input logic rdy, input logic [31:0] rd,
                     input logic eb, input logic [1:0] eg, input int er);
    vec_t t;
    t.v = v; t.rdy = rdy; t.rdata = rd; t.e_busy = eb; t.e_grant = eg; t.e_route = er;
    tbl.push_back(t);
  endtask

  task automatic drive(input logic [2:0] v, input logic rdy, input logic [31:0] rd);
    for (int i = 0; i < N; i++) m_req[i*RW +: RW] = req_of(i, v[i]);
    s_resp = {rd, rdy};
  endtask

  task automatic chk(input string name, input int row, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d act=%0h exp=%0h", name, row, act, exp);
    end
  endtask

  task automatic chk_row(input int r, input vec_t t);
    logic [RW-1:0] e_sreq;
    logic [SW-1:0] e_resp;
    chk("busy", r, 128'(busy), 128'(t.e_busy));
    chk("grant", r, 128'(grant), 128'(t.e_grant));
    e_sreq = (t.e_route < 3) ? req_of(t.e_route, t.v[t.e_route]) : '0;
    chk("s_req", r, 128'(s_req), 128'(e_sreq));
    for (int i = 0; i < N; i++) begin
      e_resp = (i == t.e_route) ? {t.rdata, t.rdy} : '0;
      chk("m_resp", r, 128'(m_resp[i*SW +: SW]), 128'(e_resp));
    end
  endtask

  localparam logic [31:0] J = 32'h0BAD_0000;

  initial begin
    rst_n = 1'b0;
    drive(3'b000, 1'b0, J);

    // Single transaction, ready on third BUSY cycle.
    add(3'b001, 1'b0, J,            1'b0, 2'd0, 3);
    add(3'b001, 1'b0, J,            1'b1, 2'd0, 0);
    add(3'b001, 1'b0, J,            1'b1, 2'd0, 0);
    add(3'b001, 1'b1, 32'hA5A5A5A5, 1'b1, 2'd0, 0);
    add(3'b000, 1'b0, J,            1'b0, 2'd0, 3);
    // All three requesting: 1,2,0,1,2 with a bubble between each grant.
    add(3'b111, 1'b0, J,            1'b0, 2'd0, 3);
    add(3'b111, 1'b1, 32'h1111_0001, 1'b1, 2'd1, 1);
    add(3'b111, 1'b0, J,            1'b0, 2'd1, 3);
    add(3'b111, 1'b1, 32'h2222_0002, 1'b1, 2'd2, 2);
    add(3'b111, 1'b0, J,            1'b0, 2'd2, 3);
    add(3'b111, 1'b1, 32'h3333_0003, 1'b1, 2'd0, 0);
    add(3'b111, 1'b0, J,            1'b0, 2'd0, 3);
    add(3'b111, 1'b1, 32'h4444_0004, 1'b1, 2'd1, 1);
    add(3'b111, 1'b0, J,            1'b0, 2'd1, 3);
    add(3'b111, 1'b1, 32'h5555_0005, 1'b1, 2'd2, 2);
    add(3'b000, 1'b0, J,            1'b0, 2'd2, 3);
    // Master1 in flight, master0 arrives late and is served next.
    add(3'b010, 1'b0, J,            1'b0, 2'd2, 3);
    add(3'b010, 1'b0, J,            1'b1, 2'd1, 1);
    add(3'b011, 1'b0, J,            1'b1, 2'd1, 1);
    add(3'b011, 1'b1, 32'h12345678, 1'b1, 2'd1, 1);
    add(3'b001, 1'b0, J,            1'b0, 2'd1, 3);
    add(3'b001, 1'b1, 32'h6666_0006, 1'b1, 2'd0, 0);
    // Abort: granted master1 drops valid, pointer moves on to master2.
    add(3'b110, 1'b0, J,            1'b0, 2'd0, 3);
    add(3'b110, 1'b0, J,            1'b1, 2'd1, 1);
    add(3'b110, 1'b0, J,            1'b1, 2'd1, 1);
    add(3'b100, 1'b0, J,            1'b1, 2'd1, 1);
    add(3'b100, 1'b0, J,            1'b0, 2'd1, 3);
    add(3'b100, 1'b1, 32'h7777_0007, 1'b1, 2'd2, 2);
    add(3'b000, 1'b0, J,            1'b0, 2'd2, 3);
    // Ready together with valid drop: response still delivered.
    add(3'b001, 1'b0, J,            1'b0, 2'd2, 3);
    add(3'b000, 1'b1, 32'hCAFEF00D, 1'b1, 2'd0, 0);
    add(3'b000, 1'b0, J,            1'b0, 2'd0, 3);

    // Reset state.
    #12;
    chk("rst_busy", -1, 128'(busy), 128'(0));
    chk("rst_grant", -1, 128'(grant), 128'(0));
    chk("rst_s_req", -1, 128'(s_req), 128'(0));
    chk("rst_m_resp", -1, 128'(m_resp), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[r]) begin
      @(negedge clk);
      drive(tbl[r].v, tbl[r].rdy, tbl[r].rdata);
      #1;
      chk_row(r, tbl[r]);
    end

    // Reset while master2 is granted: everything drops at once.
    @(negedge clk);
    drive(3'b100, 1'b0, J);
    @(negedge clk);
    #1;
    chk("pre_rst_busy", 100, 128'(busy), 128'(1));
    chk("pre_rst_grant", 100, 128'(grant), 128'(2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s_req", 101, 128'(s_req), 128'(0));
    chk("mid_rst_m_resp", 101, 128'(m_resp), 128'(0));
    chk("mid_rst_busy", 101, 128'(busy), 128'(0));
    chk("mid_rst_grant", 101, 128'(grant), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b111, 1'b0, J);
    @(negedge clk);
    #1;
    chk("post_rst_busy", 102, 128'(busy), 128'(1));
    chk("post_rst_grant", 102, 128'(grant), 128'(0));
    chk("post_rst_s_req", 102, 128'(s_req), 128'(req_of(0, 1'b1)));
    drive(3'b000, 1'b1, J);
    @(negedge clk);
    drive(3'b000, 1'b0, J);

`ifdef ARB_MERGE_TIMEOUT_EN
    // Slave never answers master1: watchdog fires on BUSY cycle 8.
    @(negedge clk);
    drive(3'b010, 1'b0, J);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      if (k < 8) begin
        chk("to_wait_resp", 200 + k, 128'(m_resp[1*SW +: SW]), 128'({J, 1'b0}));
        chk("to_wait_sreq", 200 + k, 128'(s_req), 128'(req_of(1, 1'b1)));
        chk("to_wait_err", 200 + k, 128'(timeout_err), 128'(0));
      end else begin
        chk("to_fire_resp", 200 + k, 128'(m_resp[1*SW +: SW]), 128'({SW{1'b1}}));
        chk("to_fire_sreq", 200 + k, 128'(s_req), 128'(0));
      end
    end
    @(negedge clk);
    #1;
    chk("to_idle_busy", 210, 128'(busy), 128'(0));
    chk("to_err_set", 210, 128'(timeout_err), 128'(1));
    drive(3'b011, 1'b0, J);
    @(negedge clk);
    #1;
    chk("to_next_grant", 211, 128'(grant), 128'(0));
    chk("to_next_busy", 211, 128'(busy), 128'(1));
    chk("to_err_sticky", 211, 128'(timeout_err), 128'(1));
    drive(3'b000, 1'b1, J);
    @(negedge clk);
    drive(3'b000, 1'b0, J);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb_merge.md
Name: arb_merge

Overview:
- Registered round-robin merge sitting directly upstream of the slave-side split.
- Funnels N_MASTERS native-bus masters onto one request/response pair that feeds the split's m_req/m_resp.
- Grants one master at a time and holds the grant until the slave's ready pulse closes the transaction.
- Gives fair, non-starving access to the single downstream path.

Parameters:
N_MASTERS, 2, number of upstream masters (>=1)
DATA_W, 32, data width
ADDR_W, 32, address width
TIMEOUT, 1024, watchdog limit in cycles; used only with ARB_MERGE_TIMEOUT_EN

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
m_req  input  N_MASTERS*`REQ_W  concatenated master requests, master i at `req(i)
m_resp  output  N_MASTERS*`RESP_W  concatenated master responses, master i at `resp(i)
s_req  output  `REQ_W  merged request to downstream split
s_resp  input  `RESP_W  response from downstream split
busy  output  1  transaction in flight
grant  output  max(1,$clog2(N_MASTERS))  index of current/last granted master

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low; clock port is clk, reset port is rst_n.
- Bus format (interconnect.vh):
  - REQ_W = 1+ADDR_W+DATA_W+DATA_W/8, valid at MSB.
  - RESP_W = DATA_W+1, {rdata, ready}, ready at LSB.
- Reset values: state=IDLE, busy=0, grant=0, last pointer=N_MASTERS-1 (so master 0 wins first), s_req=0, every m_resp=0.
- FSM states: IDLE, BUSY.
- IDLE:
  - Scan valid bits starting at last+1, wrapping modulo N_MASTERS; first requester wins.
  - On a win: register grant=winner, busy=1, go BUSY next edge.
  - No requester: stay IDLE, s_req=0.
- BUSY:
  - s_req = m_req of master[grant], combinational from the grant register.
  - m_resp of master[grant] = s_resp; all other m_resp = 0.
- BUSY exit: on the cycle s_resp.ready=1 (single-cycle ready pulse):
  - last<=grant, state<=IDLE.
  - s_req forced to 0 from the next cycle.
- Latency:
  - Request seen in cycle t, forwarded in t+1; min transaction is 2 cycles from valid to ready.
  - One IDLE bubble cycle between consecutive grants. There is no back-to-back grant.
- Fairness: after a master completes, every other pending master is served before it is served again. Worst-case wait is N_MASTERS-1 transactions.
- Granted master drops valid while BUSY (abort):
  - s_req valid drops the same cycle.
  - Return to IDLE next edge; last<=grant.
- ready and valid-drop in the same cycle: treated as completion. The response is delivered.
- Non-granted masters: requests are ignored. They receive m_resp=0 and must hold valid.
- N_MASTERS=1: grant is constant 0; FSM still inserts the bubble cycle.
- Reset mid-transaction: immediate return to reset values. The downstream slave sees valid drop asynchronously.

Optional Feature:
- Macro: ARB_MERGE_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on entry to BUSY and increments each BUSY cycle without ready.
  - When the count reaches TIMEOUT, the granted master gets m_resp={DATA_W{1'b1}, 1'b1} for one cycle.
  - s_req is forced to 0 that cycle; then return to IDLE, last<=grant.
  - A sticky output timeout_err (1 bit, reset 0) sets and stays set until reset.
- Undefined:
  - No counter and no timeout_err port.
  - BUSY waits indefinitely for ready.

Decomposition:
- Shared package: interconnect.vh, extended with:
  - `RESP_READY (bit 0)
  - `REQ_VALID (bit `REQ_W-1)
  - state encodings ARB_IDLE=1'b0, ARB_BUSY=1'b1
  - existing `REQ_W/`RESP_W/`req(i)/`resp(i)
- Sub-module rr_arbiter: purely combinational; inputs request vector and last pointer; outputs winner index and any_req.
- arb_merge owns the FSM, the registers and the routing.

Test Plan:
- Reset then master0 valid addr=0x10, slave ready at 3rd BUSY cycle, rdata=0xA5A5A5A5 -> grant=0, s_req valid at cycle 1, m_resp[0]=0xA5A5A5A5 with ready for one cycle, busy=0 next cycle.
- N_MASTERS=3, all three valid continuously, slave ready after 1 BUSY cycle -> grant sequence 0,1,2,0,1,2, an IDLE bubble between each grant, no master served twice in a row.
- Master1 busy, master0 raises valid mid-transaction -> master0 sees m_resp=0 and s_req unchanged until master1's ready; master0 is granted next.
- Granted master drops valid after 2 BUSY cycles, no ready -> s_req valid=0 same cycle, IDLE next cycle, round-robin pointer advanced.
- Assert rst_n=0 while BUSY -> s_req, m_resp, busy and grant all zero immediately; after release, master0 is granted first.
- With ARB_MERGE_TIMEOUT_EN, TIMEOUT=8, slave never ready -> the granted master gets ready with rdata=0xFFFFFFFF on cycle 8 of BUSY, timeout_err=1 stays high, next requester is granted.
